mem_responder: RTL and testbench

Word-addressed memory responder sitting on the CPU's memory bus: it accepts one read or write request at a time, inserts a parameterised number of wait states, then completes the access against an internal RAM or a single memory-mapped output register. It returns read data and completion status with a one-cycle `ready` pulse. It is the responder end of the CPU's `address` / `datao` / `rw` / `data` interface, extended with a `req`/`ready` handshake.

---
 rtl/mem_responder.sv | 130 +++++++++++++
 tb/tb_mem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM/IO responder; ready pulses WAIT_STATES edges after the accept edge.
// One request at a time: req is only sampled in IDLE, so a held req is simply re-accepted.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] address,
    input  logic [31:0] datao,
    output logic [31:0] data,
    output logic        ready,
    output logic        err,
    output logic [31:0] io_out,
    output logic        io_valid
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    // Counter is 4 bits wide, so WAIT_STATES must stay within 0..15.
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q;
    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic [31:0] data_q;
    logic [31:0] io_out_q;
    logic        err_q;
    logic        iov_q;

    logic [31:0] mem [2**ADDR_BITS];

    logic        latch;
    logic        do_access;
    logic        acc_rw;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdat;
    logic        ram_hit;
    logic        io_hit;
    logic [ADDR_BITS-1:0] idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        do_access = 1'b0;
        acc_rw    = rw_q;
        acc_addr  = addr_q;
        acc_wdat  = wdat_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        // No wait states: the access uses the live bus fields.
                        do_access = 1'b1;
                        acc_rw    = rw;
                        acc_addr  = address;
                        acc_wdat  = datao;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ram_hit = (acc_addr[31:ADDR_BITS] == '0);
    assign io_hit  = (acc_addr == IO_ADDR) && !ram_hit;
    assign idx     = acc_addr[ADDR_BITS-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            rw_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdat_q   <= 32'd0;
            data_q   <= 32'd0;
            io_out_q <= 32'd0;
            err_q    <= 1'b0;
            iov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                rw_q   <= rw;
                addr_q <= address;
                wdat_q <= datao;
            end
            err_q <= do_access && !ram_hit && !io_hit;
            iov_q <= do_access && io_hit && !acc_rw;
            if (do_access && acc_rw) begin
                if (ram_hit)     data_q <= mem[idx];
                else if (io_hit) data_q <= io_out_q;
                else             data_q <= 32'd0;
            end
            if (do_access && !acc_rw && io_hit) io_out_q <= acc_wdat;
        end
    end

    // RAM has no reset; the reset term keeps an aborted write from committing.
    always_ff @(posedge clock) begin
        if (reset && do_access && !acc_rw && ram_hit) mem[idx] <= acc_wdat;
    end

    assign ready    = (state_q == S_DONE);
    assign err      = err_q;
    assign io_valid = iov_q;
    assign data     = data_q;
    assign io_out   = io_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with WAIT_STATES=2, ADDR_BITS=8.
module tb_mem_responder;

    localparam logic [31:0] IO_A = 32'hFFFF_FFF0;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        rw;
    logic [31:0] address;
    logic [31:0] datao;
    logic [31:0] data;
    logic        ready;
    logic        err;
    logic [31:0] io_out;
    logic        io_valid;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder #(.ADDR_BITS(8), .WAIT_STATES(2), .IO_ADDR(IO_A)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .rw       (rw),
        .address  (address),
        .datao    (datao),
        .data     (data),
        .ready    (ready),
        .err      (err),
        .io_out   (io_out),
        .io_valid (io_valid)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction with the bus fields cleared right after the accept edge,
    // so completion must come from the latched copy.
    task automatic txn(input string tag, input logic r, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] exp_d,
                       input logic exp_e, input logic exp_v, input logic [31:0] exp_io);
        req = 1'b1; rw = r; address = a; datao = w;
        tick();
        req = 1'b0; rw = ~r; address = 32'h0000_0003; datao = 32'h5555_5555;
        chk({tag, "_rdy_e1"}, {31'd0, ready}, 32'd0);
        tick();
        chk({tag, "_rdy_e2"}, {31'd0, ready}, 32'd0);
        tick();
        chk({tag, "_rdy_done"}, {31'd0, ready}, 32'd1);
        chk({tag, "_data"}, data, exp_d);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_e});
        chk({tag, "_iov"}, {31'd0, io_valid}, {31'd0, exp_v});
        chk({tag, "_io_out"}, io_out, exp_io);
        tick();
        chk({tag, "_after"}, {29'd0, ready, err, io_valid}, 32'd0);
    endtask

    initial begin
        int n_rdy;
        int seen_rdy;
        reset = 1'b0; req = 1'b0; rw = 1'b0; address = 32'd0; datao = 32'd0;

        // Reset state
        #12;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_iov", {31'd0, io_valid}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_io_out", io_out, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_flags", {29'd0, ready, err, io_valid}, 32'd0);
            chk("idle_data", data | io_out, 32'd0);
        end

        // RAM write then read-back
        txn("wr5", 1'b0, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 32'd0);
        txn("rd5", 1'b1, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);

        // IO register
        txn("iowr", 1'b0, IO_A, 32'h0000_0041, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h41);
        tick();
        chk("io_hold", io_out, 32'h41);
        txn("iord", 1'b1, IO_A, 32'd0, 32'h41, 1'b0, 1'b0, 32'h41);

        // Out-of-range accesses
        txn("wr0", 1'b0, 32'd0, 32'h0000_0011, 32'h41, 1'b0, 1'b0, 32'h41);
        txn("miss_rd", 1'b1, 32'h0000_0100, 32'd0, 32'd0, 1'b1, 1'b0, 32'h41);
        txn("miss_wr", 1'b0, 32'h0000_0100, 32'hBAD0_BAD0, 32'd0, 1'b1, 1'b0, 32'h41);
        txn("rd0_post", 1'b1, 32'd0, 32'd0, 32'h11, 1'b0, 1'b0, 32'h41);
        txn("rd5_post", 1'b1, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h41);

        // Fill addresses 10..21 with 0x100+i
        for (int i = 0; i < 12; i++) begin
            req = 1'b1; rw = 1'b0; address = 32'(10 + i); datao = 32'(32'h100 + i);
            tick();
            req = 1'b0;
            tick(); tick(); tick();
        end

        // req held for 12 edges with the address moving every cycle:
        // accepts on edges 0, 4, 8 -> addresses 10, 14, 18.
        n_rdy = 0;
        req = 1'b1; rw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            address = 32'(10 + k);
            tick();
            chk("stream_rdy", {31'd0, ready}, {31'd0, (k % 4) == 2});
            if (ready) begin
                n_rdy++;
                chk("stream_data", data, 32'(32'h100 + (k - 2)));
            end
        end
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ready) n_rdy++;
        end
        chk("stream_count", 32'(n_rdy), 32'd3);

        // Reset in the middle of a write to address 7
        txn("wr7", 1'b0, 32'd7, 32'h0000_0001, 32'h108, 1'b0, 1'b0, 32'h41);
        req = 1'b1; rw = 1'b0; address = 32'd7; datao = 32'h0000_0099;
        tick();
        req = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("abort_rdy", {31'd0, ready}, 32'd0);
        chk("abort_io", io_out, 32'd0);
        seen_rdy = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ready) seen_rdy++;
        end
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ready) seen_rdy++;
        end
        chk("abort_no_rdy", 32'(seen_rdy), 32'd0);
        txn("rd7", 1'b1, 32'd7, 32'd0, 32'h0000_0001, 1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
